rx_deser_aligner: RTL

//  Receive-side counterpart of the 8:1 DDR OSERDES/OBUFTDS transmit path. Takes 2 bits per clk
//  (IBUFDS + IDDR pair, earlier bit on din[0]) and assembles 8-bit words, one every 4 clk.

---
 rtl/rx_deser_pkg.sv | 29 ++
 rtl/rx_deser_aligner_if.sv | 33 +++
 rtl/rx_bit_window.sv | 46 ++++
 rtl/rx_deser_aligner.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rx_deser_pkg.sv
// Shared constants and state encoding for the 2-bit-per-clock receive deserializer
// and word aligner.
package rx_deser_pkg;

  localparam int unsigned WORD_W   = 8;
  localparam int unsigned PAIR_W   = 2;
  localparam int unsigned HIST_W   = 2 * WORD_W;
  localparam int unsigned OFF_W    = 3;
  localparam int unsigned PHASE_W  = 2;
  localparam int unsigned SLIP_MAX = 8;
  localparam int unsigned SLIP_W   = 4;
  localparam int unsigned MATCH_W  = 4;
  localparam int unsigned SETTLE_W = 3;

  // Phase value on which the fourth bit pair of a word is received.
  localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEARCH = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  // Next word-boundary offset after a bit slip; wraps 7 -> 0.
  function automatic logic [OFF_W-1:0] slip_offset(input logic [OFF_W-1:0] off);
    return off + 3'd1;
  endfunction

endpackage

// File: rtl/rx_deser_aligner_if.sv
// Bit-pair input, alignment control and word/status outputs of the receive aligner.
interface rx_deser_aligner_if;
  import rx_deser_pkg::*;

  logic [PAIR_W-1:0] din;
  logic              align_req;
  logic [WORD_W-1:0] word_o;
  logic              word_valid;
  logic              aligned;
  logic              align_fail;
  logic [OFF_W-1:0]  bitslip_cnt;

  modport master (
    output din,
    output align_req,
    input  word_o,
    input  word_valid,
    input  aligned,
    input  align_fail,
    input  bitslip_cnt
  );

  modport slave (
    input  din,
    input  align_req,
    output word_o,
    output word_valid,
    output aligned,
    output align_fail,
    output bitslip_cnt
  );

endinterface

// File: rtl/rx_bit_window.sv
// Bit history, word phase counter and offset mux: produces one 8-bit word every 4 clocks
// from the window selected by the current bit-slip offset.
module rx_bit_window
  import rx_deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PAIR_W-1:0] din_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [HIST_W-1:0]  hist_q;
  logic [HIST_W-1:0]  hist_d;
  logic [PHASE_W-1:0] phase_q;
  logic [WORD_W-1:0]  word_q;
  logic               valid_q;
  logic [3:0]         base;

  // Oldest bit sits at the LSB; din[0] is the earlier bit of the pair.
  assign hist_d = {din_i[1], din_i[0], hist_q[HIST_W-1:PAIR_W]};

  // Offset 0 takes the newest 8 bits; each slip moves the window one bit older.
  assign base = 4'(WORD_W) - {1'b0, off_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      phase_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      phase_q <= phase_q + 2'd1;
      valid_q <= (phase_q == PHASE_LAST);
      if (phase_q == PHASE_LAST) begin
        word_q <= hist_d[base +: WORD_W];
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/rx_deser_aligner.sv
// Receive deserializer with training-pattern word alignment: bit-slips the word boundary
// until MATCH_COUNT consecutive words equal TRAIN_PATTERN, then holds lock.
module rx_deser_aligner
  import rx_deser_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h1F,
  parameter int unsigned       MATCH_COUNT   = 4,
  parameter int unsigned       SETTLE_WORDS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  rx_deser_aligner_if.slave bus
);

  localparam logic [MATCH_W-1:0]  MatchLast  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SETTLE_W-1:0] SettleLast =
      (SETTLE_WORDS == 0) ? '0 : SETTLE_W'(SETTLE_WORDS - 1);
  localparam logic [SLIP_W-1:0]   SlipSat    = SLIP_W'(SLIP_MAX);
  localparam logic [SLIP_W-1:0]   SlipFail   = SLIP_W'(SLIP_MAX - 1);

  logic [WORD_W-1:0]   word;
  logic                word_valid;

  state_t              state_q,  state_d;
  logic [MATCH_W-1:0]  match_q,  match_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SLIP_W-1:0]   slip_q,   slip_d;
  logic [OFF_W-1:0]    off_q,    off_d;
  logic                fail_q,   fail_d;

  rx_bit_window u_window (
    .clk          (clk),
    .rst          (rst),
    .din_i        (bus.din),
    .off_i        (off_q),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    off_d    = off_q;
    fail_d   = fail_q;

    // A restart request overrides any lock or slip decision made in the same cycle.
    if (bus.align_req) begin
      state_d  = ST_SEARCH;
      match_d  = '0;
      settle_d = '0;
      slip_d   = '0;
      fail_d   = 1'b0;
    end else if (word_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (word == TRAIN_PATTERN) begin
            if (match_q == MatchLast) begin
              state_d = ST_LOCKED;
              match_d = '0;
              fail_d  = 1'b0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d = '0;
            off_d   = slip_offset(off_q);
            if (slip_q < SlipSat) begin
              slip_d = slip_q + 4'd1;
            end
            if (slip_q >= SlipFail) begin
              fail_d = 1'b1;
            end
            settle_d = '0;
            state_d  = (SETTLE_WORDS == 0) ? ST_SEARCH : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SettleLast) begin
            state_d = ST_SEARCH;
          end else begin
            settle_d = settle_q + 3'd1;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      match_q  <= '0;
      settle_q <= '0;
      slip_q   <= '0;
      off_q    <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      settle_q <= settle_d;
      slip_q   <= slip_d;
      off_q    <= off_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.word_o      = word;
  assign bus.word_valid  = word_valid;
  assign bus.aligned     = (state_q == ST_LOCKED);
  assign bus.align_fail  = fail_q;
  assign bus.bitslip_cnt = off_q;

endmodule
